bandit_egreedy: RTL and testbench
=================================

Name: bandit_egreedy

Overview:
- Parametrised successor to the greedy bandit agent: keeps a table of signed action-value estimates and offers one action per round on a valid/ready stream.
- Consumes one reward per offered action and updates the chosen entry with a fixed-step exponential average.
- Adds configurable action count, widths and step size, epsilon-greedy exploration from an internal LFSR, explicit table initialisation, and a strict state machine.
- Sits between the environment interface and the reward source in the agent datapath.

Parameters:
- NUM_ACTIONS, 16: number of actions; power of two, 2..256. IDX_W = clog2(NUM_ACTIONS).
- VALUE_WIDTH, 16: signed width of table entries.
- REWARD_WIDTH, 16: signed reward width; must be <= VALUE_WIDTH; sign-extended to VALUE_WIDTH.
- STEP_SHIFT, 3: update step is 2^-STEP_SHIFT; range 0..VALUE_WIDTH-1.
- EPSILON, 0: exploration threshold 0..255. Explore when lfsr[15:8] < EPSILON; 0 disables exploration.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- reward_valid  in  1  reward present.
- reward_data  in  REWARD_WIDTH  signed reward for the last accepted action.
- reward_ready  out  1  block accepts a reward.
- action_valid  out  1  action offered.
- action_data  out  IDX_W  offered action index.
- action_explore  out  1  offered action was chosen by exploration.
- action_ready  in  1  consumer accepts the action.

Behaviour:
- Reset (reset=0), asynchronous: state=INIT, init/scan counter=0, lfsr=LFSR_SEED, reward_ready=0, action_valid=0, action_data=0, action_explore=0. Table contents are not reset by the reset itself; INIT clears them.
- The LFSR is a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1. It advances on every clock edge out of reset.
- INIT: writes 0 to entry k on edge k+1 for k=0..NUM_ACTIONS-1, then enters SCAN.
- SCAN: synchronous table read, one entry per cycle, 1-cycle read latency. Takes NUM_ACTIONS+1 edges.
  - Running best is seeded with entry 0, then replaced only when an entry is strictly greater (signed). Ties go to the lowest index.
  - On the final scan edge:
    - Sample lfsr. If lfsr[15:8] < EPSILON: action_data = lfsr[IDX_W-1:0] and action_explore=1.
    - Otherwise: action_data = best index and action_explore=0.
    - Set action_valid=1 and go to OFFER.
- Latency: with EPSILON=0, action_valid first rises after exactly 2*NUM_ACTIONS+1 edges following reset release. Each later round takes 1 (UPDATE) + NUM_ACTIONS+1 (SCAN) edges from reward handshake to action_valid.
- OFFER:
  - action_valid, action_data and action_explore stay stable until action_valid & action_ready.
  - On that edge: action_valid=0, reward_ready=1, go to WAIT.
  - reward_valid is ignored in OFFER.
- WAIT:
  - reward_ready=1 until reward_valid & reward_ready.
  - On that edge: reward_ready=0, latch the reward, go to UPDATE.
  - action_ready is ignored in WAIT.
- UPDATE: one edge. table[a] <= v + ((r - v) >>> STEP_SHIFT), where:
  - a = action_data, v = table[a], r = sign-extended reward.
  - The difference is computed in VALUE_WIDTH+1 bits with an arithmetic (floor) shift.
  - The result lies between v and r inclusive, so it fits in VALUE_WIDTH with no saturation.
  - Then go to SCAN.
- Only one outstanding action at a time. reward_ready and action_valid are never high in the same cycle.
- Reset mid-operation: any state returns to INIT immediately, outputs drop asynchronously, and the table is re-cleared. A pending reward is lost.
- NUM_ACTIONS=2: IDX_W=1, same timing rules apply.

Test Plan:
- NUM_ACTIONS=4, EPSILON=0, release reset -> action_valid rises after 9 edges with action_data=0, action_explore=0 (all-zero tie resolves to lowest index).
- Accept action 0, reward 800 -> reward_ready high the next cycle; after handshake table[0]=100; next offer is action_data=0 (100 > 0).
- From that state, accept action 0, reward -800 -> table[0] = 100 + (-900>>>3) = -13; next offer is action_data=1 (lowest-index zero).
- Hold action_ready=0 for 20 cycles during OFFER, toggle reward_valid -> action_valid/data/explore stable, reward_ready stays 0, no table change.
- Assert reset during WAIT -> reward_ready=0 within the same cycle (asynchronous); after release, 9 edges to an offer of action 0 with the table fully cleared.
- EPSILON=255, LFSR_SEED=16'hACE1 -> action_explore and action_data match a software LFSR model sampled on the final scan edge for 100 rounds; mark action_explore=0 rounds only where lfsr[15:8]=255.

Source files
------------

// File: rtl/bandit_egreedy.sv
// bandit_egreedy
// Epsilon-greedy multi-armed bandit agent. Holds a table of signed action-value
// estimates, offers one action per round on a valid/ready stream, then consumes
// one reward and moves the chosen estimate toward it by 2^-STEP_SHIFT.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   reward_valid   reward present
//   reward_data    signed reward for the last accepted action
//   reward_ready   block accepts a reward
//   action_valid   action offered
//   action_data    offered action index
//   action_explore offered action came from the exploration path
//   action_ready   consumer accepts the action
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_INIT   | clear table entry cnt each edge, NUM_ACTIONS edges
// S_SCAN   | stream table through the read port, track best, pick action
// S_OFFER  | hold action until action_ready
// S_WAIT   | hold reward_ready until reward_valid, latch reward
// S_UPDATE | write exponential-average update into table[action_data]
module bandit_egreedy #(
  parameter int NUM_ACTIONS  = 16,
  parameter int VALUE_WIDTH  = 16,
  parameter int REWARD_WIDTH = 16,
  parameter int STEP_SHIFT   = 3,
  parameter int EPSILON      = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int IDX_W = $clog2(NUM_ACTIONS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           reward_valid,
  input  logic signed [REWARD_WIDTH-1:0] reward_data,
  output logic                           reward_ready,
  output logic                           action_valid,
  output logic [IDX_W-1:0]               action_data,
  output logic                           action_explore,
  input  logic                           action_ready
);

  typedef enum logic [2:0] {S_INIT, S_SCAN, S_OFFER, S_WAIT, S_UPDATE} state_t;

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT_LAST = CNT_W'(NUM_ACTIONS - 1);
  localparam logic [CNT_W-1:0] CNT_SCAN_LAST = CNT_W'(NUM_ACTIONS);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [7:0]       EPS           = 8'(EPSILON);
  localparam logic [15:0]      LFSR_TAPS     = 16'hB400;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [15:0]                    lfsr;
  logic signed [VALUE_WIDTH-1:0]  val_tbl [NUM_ACTIONS];
  logic signed [VALUE_WIDTH-1:0]  rd_data;
  logic signed [VALUE_WIDTH-1:0]  best_val;
  logic [IDX_W-1:0]               best_idx;
  logic signed [VALUE_WIDTH-1:0]  reward_q;

  logic [IDX_W-1:0]               rd_addr;
  logic [IDX_W-1:0]               wr_addr;
  logic                           wr_en;
  logic signed [VALUE_WIDTH-1:0]  wr_data;
  logic [IDX_W-1:0]               scan_idx;
  logic [IDX_W-1:0]               pick_idx;
  logic                           take;
  logic                           explore;
  logic signed [VALUE_WIDTH:0]    diff;
  logic signed [VALUE_WIDTH-1:0]  upd_val;

  always_comb begin
    // rd_data during SCAN holds entry cnt-1; cnt==1 seeds the running best.
    scan_idx = IDX_W'(cnt - CNT_ONE);
    take     = (cnt == CNT_ONE) || (rd_data > best_val);
    pick_idx = take ? scan_idx : best_idx;
    explore  = (lfsr[15:8] < EPS);
    rd_addr  = (state == S_SCAN) ? IDX_W'(cnt) : action_data;
    // One extra bit keeps r - v exact; the floor-shifted step added to v lands
    // between v and r, so truncating back to VALUE_WIDTH is lossless.
    diff     = {reward_q[VALUE_WIDTH-1], reward_q} - {rd_data[VALUE_WIDTH-1], rd_data};
    upd_val  = rd_data + VALUE_WIDTH'(diff >>> STEP_SHIFT);
    wr_en    = (state == S_INIT) || (state == S_UPDATE);
    wr_addr  = (state == S_INIT) ? IDX_W'(cnt) : action_data;
    wr_data  = (state == S_INIT) ? '0 : upd_val;
  end

  // Table has no reset so it maps onto RAM; INIT clears it instead.
  // In WAIT the read port points at action_data, so UPDATE sees v in rd_data.
  always_ff @(posedge clock) begin
    if (wr_en) val_tbl[wr_addr] <= wr_data;
    rd_data <= val_tbl[rd_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_INIT;
      cnt            <= '0;
      lfsr           <= LFSR_SEED;
      best_val       <= '0;
      best_idx       <= '0;
      reward_q       <= '0;
      reward_ready   <= 1'b0;
      action_valid   <= 1'b0;
      action_data    <= '0;
      action_explore <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      case (state)
        S_INIT: begin
          if (cnt == CNT_INIT_LAST) begin
            cnt   <= '0;
            state <= S_SCAN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SCAN: begin
          if (cnt == CNT_SCAN_LAST) begin
            cnt            <= '0;
            action_data    <= explore ? lfsr[IDX_W-1:0] : pick_idx;
            action_explore <= explore;
            action_valid   <= 1'b1;
            state          <= S_OFFER;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt != '0) begin
              if (take) best_val <= rd_data;
              best_idx <= pick_idx;
            end
          end
        end
        S_OFFER: begin
          if (action_ready) begin
            action_valid <= 1'b0;
            reward_ready <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (reward_valid) begin
            reward_ready <= 1'b0;
            reward_q     <= VALUE_WIDTH'(reward_data);
            state        <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          cnt   <= '0;
          state <= S_SCAN;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bandit_egreedy.sv
// Bench for bandit_egreedy: a greedy instance (EPSILON=0) and an always-explore
// instance (EPSILON=255), both with four actions, checked against a table model
// and a software LFSR.
module tb_bandit_egreedy;

  localparam int NA = 4;

  logic clock;
  logic rst0, rv0, rr0, av0, ax0, ar0;
  logic signed [15:0] rd0;
  logic [1:0] ad0;
  logic rst1, rv1, rr1, av1, ax1, ar1;
  logic signed [15:0] rd1;
  logic [1:0] ad1;

  int checks = 0;
  int errors = 0;
  int tbl0 [NA];
  int tbl1 [NA];
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_prev = 16'hACE1;

  bandit_egreedy #(.NUM_ACTIONS(NA), .EPSILON(0)) u0 (
    .clock(clock), .reset(rst0), .reward_valid(rv0), .reward_data(rd0),
    .reward_ready(rr0), .action_valid(av0), .action_data(ad0),
    .action_explore(ax0), .action_ready(ar0));

  bandit_egreedy #(.NUM_ACTIONS(NA), .EPSILON(255), .LFSR_SEED(16'hACE1)) u1 (
    .clock(clock), .reset(rst1), .reward_valid(rv1), .reward_data(rd1),
    .reward_ready(rr1), .action_valid(av1), .action_data(ad1),
    .action_explore(ax1), .action_ready(ar1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Software LFSR: m_prev is the value the DUT saw at the most recent edge.
  always @(posedge clock) begin
    if (!rst1) m_lfsr = 16'hACE1;
    else begin
      m_prev = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  function automatic int best_of(input int t [NA]);
    int b = 0;
    for (int i = 1; i < NA; i++) if (t[i] > t[b]) b = i;
    return b;
  endfunction

  // v + floor((r - v) / 8)
  function automatic int upd(input int v, input int r);
    int d = r - v;
    int step;
    if (d >= 0) step = d / 8;
    else step = -((-d + 7) / 8);
    return v + step;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_offer0(output int e);
    e = 0;
    while (!av0 && e < 200) begin @(negedge clock); e++; end
  endtask

  task automatic wait_offer1(output int e);
    e = 0;
    while (!av1 && e < 200) begin @(negedge clock); e++; end
  endtask

  // One full greedy round on u0; entered and left on a negedge.
  task automatic round0(input int r, input int exp_lat);
    int e;
    int idx;
    wait_offer0(e);
    check("lat0", e, exp_lat);
    check("valid0", av0, 1);
    idx = best_of(tbl0);
    check("act0", ad0, idx);
    check("expl0", ax0, 0);
    check("rr0_offer", rr0, 0);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    ar0 = 1'b1;
    @(negedge clock);
    ar0 = 1'b0;
    check("av0_drop", av0, 0);
    check("rr0_up", rr0, 1);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    rd0 = 16'(r);
    rv0 = 1'b1;
    @(negedge clock);
    rv0 = 1'b0;
    check("rr0_drop", rr0, 0);
    tbl0[idx] = upd(tbl0[idx], r);
  endtask

  function automatic int rand_reward();
    if ($urandom_range(0, 3) == 0) return 0;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int e;
    int idx;
    int r;
    int greedy_rounds = 0;
    logic ex;
    logic [1:0] hold_ad;
    rst0 = 0; rv0 = 0; ar0 = 0; rd0 = '0;
    rst1 = 0; rv1 = 0; ar1 = 0; rd1 = '0;
    for (int i = 0; i < NA; i++) begin tbl0[i] = 0; tbl1[i] = 0; end
    repeat (3) @(negedge clock);
    check("rst_av", av0, 0);
    check("rst_rr", rr0, 0);
    check("rst_ad", ad0, 0);
    check("rst_ax", ax0, 0);

    rst0 = 1;
    round0(800, 2 * NA + 1);
    check("tbl0_after_800", tbl0[0], 100);
    round0(-800, NA + 2);
    check("tbl0_after_m800", tbl0[0], -13);

    // Offer stall with reward_valid wiggling; nothing may move.
    wait_offer0(e);
    check("lat0_hold", e, NA + 2);
    check("act0_hold", ad0, 1);
    hold_ad = ad0;
    for (int i = 0; i < 20; i++) begin
      rv0 = i[0];
      rd0 = 16'(i * 1000);
      @(negedge clock);
      check("hold_av", av0, 1);
      check("hold_ad", ad0, 1);
      check("hold_ax", ax0, 0);
      check("hold_rr", rr0, 0);
    end
    rv0 = 0;
    check("hold_ad_stable", ad0, hold_ad);
    ar0 = 1;
    @(negedge clock);
    ar0 = 0;
    check("wait_rr", rr0, 1);
    // Asynchronous reset in the middle of WAIT.
    #2 rst0 = 0;
    #1;
    check("async_rr", rr0, 0);
    check("async_av", av0, 0);
    @(negedge clock);
    rst0 = 1;
    for (int i = 0; i < NA; i++) tbl0[i] = 0;
    round0(rand_reward(), 2 * NA + 1);
    for (int k = 0; k < 30; k++) round0(rand_reward(), NA + 2);

    // Exploration instance against the software LFSR.
    rst1 = 1;
    for (int k = 0; k < 100; k++) begin
      wait_offer1(e);
      check("lat1", e, (k == 0) ? 2 * NA + 1 : NA + 2);
      check("valid1", av1, 1);
      ex = (m_prev[15:8] < 8'd255);
      idx = ex ? int'(m_prev[1:0]) : best_of(tbl1);
      if (!ex) greedy_rounds++;
      check("expl1", ax1, ex);
      check("act1", ad1, idx);
      check("rr1_offer", rr1, 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      ar1 = 1;
      @(negedge clock);
      ar1 = 0;
      check("rr1_up", rr1, 1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      r = rand_reward();
      rd1 = 16'(r);
      rv1 = 1;
      @(negedge clock);
      rv1 = 0;
      check("rr1_drop", rr1, 0);
      tbl1[idx] = upd(tbl1[idx], r);
    end
    $display("exploration rounds %0d greedy rounds %0d", 100 - greedy_rounds, greedy_rounds);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
